// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// MDU_FAST_MUL_EN selects a single-cycle multiplier instead of shift-add iteration.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITER  = 32;
  localparam int MDU_CNT_W = $clog2(MDU_ITER);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_MUL2 = 2'd2,
    S_DONE = 2'd3
  } mdu_state_t;

  // Magnitude of a two's-complement value; the most negative value maps to itself as unsigned.
  function automatic logic [MDU_WIDTH-1:0] mdu_mag(input logic [MDU_WIDTH-1:0] x,
                                                   input logic is_signed);
    return (is_signed && x[MDU_WIDTH-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Iterative datapath: one restoring-divide step (or one shift-add multiply step) per enable.
// rem/quo registers double as the 2*WIDTH product accumulator in multiply mode.
module mdu_div_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             mul_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] rem_nxt_o,
  output logic [WIDTH-1:0] quo_nxt_o,
  output logic             last_o
);

  logic [WIDTH-1:0]     rem_q, quo_q, dvs_q;
  logic                 mul_q;
  logic [MDU_CNT_W-1:0] cnt_q;
  logic [WIDTH:0]       shifted, diff, sum;

  assign last_o = (cnt_q == MDU_CNT_W'(MDU_ITER - 1));

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    sum     = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : '0);
    if (mul_q) begin
      rem_nxt_o = sum[WIDTH:1];
      quo_nxt_o = {sum[0], quo_q[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      // Trial subtraction did not borrow: keep it and shift in a 1.
      rem_nxt_o = diff[WIDTH-1:0];
      quo_nxt_o = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt_o = shifted[WIDTH-1:0];
      quo_nxt_o = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      mul_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      rem_q <= '0;
      quo_q <= a_i;
      dvs_q <= b_i;
      mul_q <= mul_i;
      cnt_q <= '0;
    end else if (en_i) begin
      rem_q <= rem_nxt_o;
      quo_q <= quo_nxt_o;
      cnt_q <= cnt_q + MDU_CNT_W'(1);
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer owning all HI/LO writes; stalls via busy while an op runs.
// Define MDU_FAST_MUL_EN for a registered single-cycle multiplier (MUL2 state).
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_wdata,
  output logic [WIDTH-1:0] lo_wdata
);

  mdu_state_t         state_q, state_d;
  mdu_op_t            op;
  logic               accept, is_mul, is_div, sgn_op, div_zero;
  logic               neg_q, rem_neg_q, is_mul_q;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               it_start, it_en, it_last;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   div_hi, div_lo;
  logic               hi_we_d, lo_we_d;
  logic [WIDTH-1:0]   hi_wdata_d, lo_wdata_d;

  assign op       = mdu_op_t'(op_code);
  assign accept   = (state_q == S_IDLE) && op_valid && !flush;
  assign is_mul   = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
  assign sgn_op   = (op == OP_MULT) || (op == OP_DIV);
  assign div_zero = (op_b == '0);
  assign mag_a    = mdu_mag(op_a, sgn_op);
  assign mag_b    = mdu_mag(op_b, sgn_op);
  assign busy     = (state_q != S_IDLE);

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod_q;

  assign it_start = accept && is_div && !div_zero;
  assign prod_raw = prod_q;

  always_ff @(posedge clk) begin
    if (rst) prod_q <= '0;
    else if (accept && is_mul) prod_q <= {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
  end
`else
  assign it_start = accept && (is_mul || (is_div && !div_zero));
  assign prod_raw = {rem_nxt, quo_nxt};
`endif

  assign it_en = (state_q == S_RUN);

  mdu_div_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .start_i   (it_start),
    .mul_i     (is_mul),
    .en_i      (it_en),
    .a_i       (mag_a),
    .b_i       (mag_b),
    .rem_nxt_o (rem_nxt),
    .quo_nxt_o (quo_nxt),
    .last_o    (it_last)
  );

  // Sign fix-up works on magnitudes: quotient/product follow sign(a)^sign(b), remainder follows sign(a).
  assign prod_fix = neg_q ? -prod_raw : prod_raw;
  assign div_lo   = neg_q ? -quo_nxt : quo_nxt;
  assign div_hi   = rem_neg_q ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      is_mul_q  <= 1'b0;
    end else if (accept) begin
      neg_q     <= sgn_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      rem_neg_q <= sgn_op && op_a[WIDTH-1];
      is_mul_q  <= is_mul;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_mul) begin
`ifdef MDU_FAST_MUL_EN
          state_d = S_MUL2;
`else
          state_d = S_RUN;
`endif
        end else if (accept && is_div) begin
          state_d = div_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (flush)        state_d = S_IDLE;
        else if (it_last) state_d = S_DONE;
      end
      S_MUL2:  state_d = flush ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write strobes are computed one cycle early so the enables and data are registered in DONE.
  always_comb begin
    hi_we_d    = 1'b0;
    lo_we_d    = 1'b0;
    hi_wdata_d = hi_wdata;
    lo_wdata_d = lo_wdata;
    case (state_q)
      S_IDLE: begin
        if (accept && op == OP_MTHI) begin
          hi_we_d    = 1'b1;
          hi_wdata_d = op_a;
        end else if (accept && op == OP_MTLO) begin
          lo_we_d    = 1'b1;
          lo_wdata_d = op_a;
        end else if (accept && is_div && div_zero) begin
          hi_we_d    = 1'b1;
          lo_we_d    = 1'b1;
          hi_wdata_d = op_a;
          lo_wdata_d = '1;
        end
      end
      S_RUN: begin
        if (!flush && it_last) begin
          hi_we_d = 1'b1;
          lo_we_d = 1'b1;
          if (is_mul_q) begin
            hi_wdata_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_wdata_d = prod_fix[WIDTH-1:0];
          end else begin
            hi_wdata_d = div_hi;
            lo_wdata_d = div_lo;
          end
        end
      end
      S_MUL2: begin
        if (!flush) begin
          hi_we_d    = 1'b1;
          lo_we_d    = 1'b1;
          hi_wdata_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_wdata_d = prod_fix[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_we    <= 1'b0;
      lo_we    <= 1'b0;
      hi_wdata <= '0;
      lo_wdata <= '0;
    end else begin
      hi_we    <= hi_we_d;
      lo_we    <= lo_we_d;
      hi_wdata <= hi_wdata_d;
      lo_wdata <= lo_wdata_d;
    end
  end

endmodule
